// File: rtl/fb_divider.sv
// Programmable integer feedback divider for the PLL feedback path.
// It is clocked by the VCO output and divides it by N to drive the PFD feedback input (ckdiv).
// A new N is requested with a level-sensitive load/load_ack handshake.
// The new N is adopted only on a period boundary (cnt == 0), so ckdiv never produces a runt pulse.
//
// Ports:
//   clk      divider clock (VCO cko), rising edge
//   rst      asynchronous active-high reset
//   en       count enable; low freezes all state
//   div_in   requested modulus (clamped up to NMIN)
//   load     request level, held until load_ack
//   load_ack one-cycle pulse on the edge where the new N becomes active
//   pending  a captured request is waiting for the period boundary
//   ckdiv    divided clock: high ceil(N/2) cycles, low floor(N/2) cycles
//   tc       terminal count, high in the last cycle of a period
//   cnt      current down-counter value
module fb_divider #(
  parameter int unsigned W     = 8,
  parameter int unsigned NMIN  = 2,
  parameter int unsigned N_RST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_in,
  input  logic         load,
  output logic         load_ack,
  output logic         pending,
  output logic         ckdiv,
  output logic         tc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] NMinW = W'(NMIN);
  localparam logic [W-1:0] NRstW = W'(N_RST);
  localparam logic [W-1:0] OneW  = W'(1);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] n_act_q, n_act_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic         pending_q, pending_d;
  logic         load_ack_q, load_ack_d;
  logic         ckdiv_q, ckdiv_d;
  logic         tc_q, tc_d;

  logic         boundary;
  logic         req_ok;
  logic [W-1:0] div_clamped;

  always_comb begin
    boundary    = en && (cnt_q == '0);
    // A load still high during the ack cycle belongs to the request just acknowledged.
    req_ok      = en && load && !load_ack_q;
    div_clamped = (div_in < NMinW) ? NMinW : div_in;

    cnt_d      = cnt_q;
    n_act_d    = n_act_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    load_ack_d = 1'b0;
    ckdiv_d    = ckdiv_q;
    tc_d       = tc_q;

    if (boundary) begin
      if (pending_q) begin
        n_act_d    = shadow_q;
        pending_d  = 1'b0;
        load_ack_d = 1'b1;
      end else if (req_ok) begin
        // Request arriving exactly on the boundary bypasses the shadow register.
        n_act_d    = div_clamped;
        shadow_d   = div_clamped;
        load_ack_d = 1'b1;
      end
      cnt_d = n_act_d - OneW;
    end else if (en) begin
      cnt_d = cnt_q - OneW;
      if (req_ok) begin
        shadow_d  = div_clamped;
        pending_d = 1'b1;
      end
    end

    if (en) begin
      ckdiv_d = (cnt_d >= (n_act_d >> 1));
      tc_d    = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      n_act_q    <= NRstW;
      shadow_q   <= NRstW;
      pending_q  <= 1'b0;
      load_ack_q <= 1'b0;
      ckdiv_q    <= 1'b0;
      tc_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      n_act_q    <= n_act_d;
      shadow_q   <= shadow_d;
      pending_q  <= pending_d;
      load_ack_q <= load_ack_d;
      ckdiv_q    <= ckdiv_d;
      tc_q       <= tc_d;
    end
  end

  assign cnt      = cnt_q;
  assign ckdiv    = ckdiv_q;
  assign tc       = tc_q;
  assign load_ack = load_ack_q;
  assign pending  = pending_q;

endmodule
